// File: rtl/ni_rx_checker_pkg.sv
// Shared definitions for the NI receive checker: status error bit positions,
// FSM state constants and flit field helpers.
package ni_rx_checker_pkg;

  // Bit positions inside the 2-bit status error field.
  localparam int CHK_ERR  = 0;
  localparam int ADDR_ERR = 1;
  localparam int ERR_W    = 2;

  // Packet reassembly FSM states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BODY = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  // Flit layout: {tail, addr[ADDR_SIZE], data[DATA_SIZE]}.
  function automatic int flit_tail_idx(input int data_size, input int addr_size);
    return data_size + addr_size;
  endfunction

  function automatic int flit_addr_msb(input int data_size, input int addr_size);
    return data_size + addr_size - 1;
  endfunction

endpackage

// File: rtl/ni_rx_checker_sync_fifo.sv
// Small synchronous FIFO with async active-low reset. The head entry is
// presented combinationally; push while full is honoured only with a pop.
module sync_fifo #(
  parameter int WIDTH      = 10,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  assign full_o    = (cnt_q == FULL_CNT);
  assign empty_o   = (cnt_q == '0);
  assign data_o    = mem_q[rd_ptr_q];
  assign pop_ok_s  = pop_i && !empty_o;
  // When full, the slot under wr_ptr is the one being popped this edge.
  assign push_ok_s = push_i && (!full_o || pop_ok_s);

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   cnt_d = cnt_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   cnt_d = cnt_q - (DEPTH_LOG2 + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/ni_rx_checker.sv
// Receive-side NI checker: reassembles flits into packets, checks address,
// length and XOR checksum, and queues one status record per packet.
module ni_rx_checker
  import ni_rx_checker_pkg::*;
#(
  parameter int DATA_SIZE    = 8,
  parameter int ADDR_SIZE    = 4,
  parameter int ADDR         = 0,
  parameter int MAX_PACK_LEN = 8,
  parameter int LEN_SIZE     = 8,
  parameter int STAT_LOG2    = 2,
  parameter int FLIT_SIZE    = DATA_SIZE + ADDR_SIZE + 1
) (
  input  logic                 clk,
  input  logic                 a_rst,
  input  logic [FLIT_SIZE-1:0] data_i,
  input  logic                 wr_ready_in,
  output logic                 r_ready_out,
  output logic                 st_valid,
  input  logic                 st_ready,
  output logic [LEN_SIZE-1:0]  st_len,
  output logic [1:0]           st_err,
  output logic [31:0]          recv_packs,
  output logic [31:0]          err_packs
);

  localparam int TAIL_IDX = flit_tail_idx(DATA_SIZE, ADDR_SIZE);
  localparam int ADDR_MSB = flit_addr_msb(DATA_SIZE, ADDR_SIZE);
  localparam logic [ADDR_SIZE-1:0] MY_ADDR = ADDR_SIZE'(ADDR);
  localparam logic [LEN_SIZE-1:0]  LEN_MAX = LEN_SIZE'(MAX_PACK_LEN);
  localparam logic [LEN_SIZE-1:0]  LEN_SAT = LEN_SIZE'(MAX_PACK_LEN + 1);

  // Flit fields
  logic                 tail_s;
  logic [ADDR_SIZE-1:0] addr_s;
  logic [DATA_SIZE-1:0] dat_s;
  logic                 addr_bad_s;

  // Per-packet state
  logic [1:0]           state_q, state_d;
  logic [LEN_SIZE-1:0]  len_q, len_d;
  logic [LEN_SIZE-1:0]  len_inc_s;
  logic [DATA_SIZE-1:0] xor_q, xor_d;
  logic                 addr_err_q, addr_err_d;
  logic                 len_err_q, len_err_d;

  // Completion / FIFO
  logic                  accept_s;
  logic                  push_s;
  logic                  pop_s;
  logic [ERR_W-1:0]      rec_err_s;
  logic [LEN_SIZE+1:0]   head_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [31:0]           recv_packs_q;
  logic [31:0]           err_packs_q;

  assign tail_s     = data_i[TAIL_IDX];
  assign addr_s     = data_i[ADDR_MSB -: ADDR_SIZE];
  assign dat_s      = data_i[DATA_SIZE-1:0];
  assign addr_bad_s = (addr_s != MY_ADDR);

  assign r_ready_out = a_rst && !fifo_full_s;
  assign accept_s    = wr_ready_in && r_ready_out;
  // Length counter saturates so an arbitrarily long dropped packet stays bounded.
  assign len_inc_s   = (len_q == LEN_SAT) ? len_q : (len_q + LEN_SIZE'(1));

  // Reassembly FSM and per-packet check accumulation.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    xor_d      = xor_q;
    addr_err_d = addr_err_q;
    len_err_d  = len_err_q;
    push_s     = 1'b0;
    rec_err_s  = '0;
    if (accept_s) begin
      len_d      = len_inc_s;
      addr_err_d = addr_err_q | addr_bad_s;
      case (state_q)
        ST_IDLE, ST_BODY: begin
          if (tail_s) begin
            push_s              = 1'b1;
            rec_err_s[CHK_ERR]  = (dat_s != xor_q);
            rec_err_s[ADDR_ERR] = addr_err_q | addr_bad_s | len_err_q;
            state_d             = ST_IDLE;
          end else if (len_inc_s >= LEN_MAX) begin
            // Hit the length limit without a tail: stop checksumming.
            xor_d     = xor_q ^ dat_s;
            len_err_d = 1'b1;
            state_d   = ST_DROP;
          end else begin
            xor_d   = xor_q ^ dat_s;
            state_d = ST_BODY;
          end
        end
        ST_DROP: begin
          if (tail_s) begin
            // The tail of an over-long packet carries no meaningful checksum.
            push_s              = 1'b1;
            rec_err_s[ADDR_ERR] = addr_err_q | addr_bad_s | len_err_q;
            state_d             = ST_IDLE;
          end else begin
            state_d = ST_DROP;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
      if (push_s) begin
        len_d      = '0;
        xor_d      = '0;
        addr_err_d = 1'b0;
        len_err_d  = 1'b0;
      end else begin
        len_d = len_inc_s;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Per-packet state registers.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      xor_q      <= '0;
      addr_err_q <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      xor_q      <= xor_d;
      addr_err_q <= addr_err_d;
      len_err_q  <= len_err_d;
    end
  end

  // Running packet counters, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      recv_packs_q <= 32'd0;
      err_packs_q  <= 32'd0;
    end else if (push_s) begin
      recv_packs_q <= recv_packs_q + 32'd1;
      if (rec_err_s != '0) begin
        err_packs_q <= err_packs_q + 32'd1;
      end
    end
  end

  assign recv_packs = recv_packs_q;
  assign err_packs  = err_packs_q;

  assign st_valid = !fifo_empty_s;
  assign pop_s    = st_valid && st_ready;
  assign st_len   = head_s[LEN_SIZE+1:ERR_W];
  assign st_err   = head_s[ERR_W-1:0];

  sync_fifo #(
    .WIDTH      (LEN_SIZE + ERR_W),
    .DEPTH_LOG2 (STAT_LOG2)
  ) u_stat_fifo (
    .clk_i   (clk),
    .rst_ni  (a_rst),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  ({len_inc_s, rec_err_s}),
    .data_o  (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

endmodule

// File: tb/tb_ni_rx_checker.sv
// Self-checking bench for ni_rx_checker: directed packets plus randomized
// packets checked against a packet-level reference model.
module tb_ni_rx_checker;

  localparam int DS   = 8;
  localparam int AS   = 4;
  localparam int FS   = DS + AS + 1;
  localparam int MY   = 3;
  localparam int MAXP = 4;
  localparam int LS   = 8;

  logic          clk;
  logic          a_rst;
  logic [FS-1:0] data_i;
  logic          wr_ready_in;
  logic          r_ready_out;
  logic          st_valid;
  logic          st_ready;
  logic [LS-1:0] st_len;
  logic [1:0]    st_err;
  logic [31:0]   recv_packs;
  logic [31:0]   err_packs;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int exp_recv = 0;
  int exp_err  = 0;
  logic [FS-1:0] pkt_q[$];

  ni_rx_checker #(
    .DATA_SIZE(DS), .ADDR_SIZE(AS), .ADDR(MY), .MAX_PACK_LEN(MAXP),
    .LEN_SIZE(LS), .STAT_LOG2(1)
  ) dut (
    .clk(clk), .a_rst(a_rst), .data_i(data_i), .wr_ready_in(wr_ready_in),
    .r_ready_out(r_ready_out), .st_valid(st_valid), .st_ready(st_ready),
    .st_len(st_len), .st_err(st_err), .recv_packs(recv_packs),
    .err_packs(err_packs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [FS-1:0] mk(input logic t, input logic [AS-1:0] a, input logic [DS-1:0] d);
    return {t, a, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Present one flit and hold it until accepted (bounded wait). Ends at a negedge.
  task automatic send_flit(input logic [FS-1:0] f);
    int waited = 0;
    data_i = f;
    wr_ready_in = 1'b1;
    while (!r_ready_out && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1 wr_ready_in = 1'b0;
    @(negedge clk);
  endtask

  // Send pkt_q, then compare the status record and counters with the model.
  task automatic run_packet(input string tag);
    int n;
    logic [DS-1:0] acc;
    logic bad_addr, len_bad, chk_bad;
    int elen;
    logic [1:0] eerr;
    n = pkt_q.size();
    acc = '0;
    bad_addr = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (pkt_q[i][FS-2 -: AS] != 4'(MY)) bad_addr = 1'b1;
      if (i < n - 1) acc = acc ^ pkt_q[i][DS-1:0];
    end
    len_bad = (n > MAXP);
    chk_bad = !len_bad && (pkt_q[n-1][DS-1:0] != acc);
    elen = (n > MAXP + 1) ? MAXP + 1 : n;
    eerr = {bad_addr | len_bad, chk_bad};
    exp_recv++;
    if (eerr != 2'b00) exp_err++;
    for (int i = 0; i < n; i++) send_flit(pkt_q[i]);
    chk({tag, "_valid"}, 32'(st_valid), 32'd1);
    chk({tag, "_len"}, 32'(st_len), 32'(elen));
    chk({tag, "_err"}, 32'(st_err), 32'(eerr));
    chk({tag, "_recv"}, recv_packs, 32'(exp_recv));
    chk({tag, "_errp"}, err_packs, 32'(exp_err));
    st_ready = 1'b1;
    @(posedge clk);
    #1 st_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_popped"}, 32'(st_valid), 32'd0);
  endtask

  initial begin
    logic [DS-1:0] acc;
    logic [AS-1:0] a;
    logic [DS-1:0] d;
    int n;
    a_rst = 1'b0;
    data_i = '0;
    wr_ready_in = 1'b0;
    st_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", 32'(r_ready_out), 32'd0);
    chk("rst_valid", 32'(st_valid), 32'd0);
    chk("rst_len", 32'(st_len), 32'd0);
    chk("rst_err", 32'(st_err), 32'd0);
    chk("rst_recv", recv_packs, 32'd0);
    chk("rst_errp", err_packs, 32'd0);
    a_rst = 1'b1;
    @(negedge clk);
    chk("idle_rdy", 32'(r_ready_out), 32'd1);

    pkt_q = '{mk(1'b0, 4'd3, 8'h12), mk(1'b0, 4'd3, 8'h34), mk(1'b1, 4'd3, 8'h26)};
    run_packet("good");
    pkt_q = '{mk(1'b0, 4'd3, 8'h12), mk(1'b0, 4'd3, 8'h34), mk(1'b1, 4'd3, 8'h00)};
    run_packet("badchk");
    pkt_q = '{mk(1'b1, 4'd3, 8'h00)};
    run_packet("single");
    pkt_q = '{mk(1'b0, 4'd3, 8'h12), mk(1'b0, 4'd5, 8'h34), mk(1'b1, 4'd3, 8'h26)};
    run_packet("badaddr");
    pkt_q = '{mk(1'b0, 4'd3, 8'h01), mk(1'b0, 4'd3, 8'h02), mk(1'b0, 4'd3, 8'h04),
              mk(1'b0, 4'd3, 8'h08), mk(1'b0, 4'd3, 8'h10), mk(1'b1, 4'd3, 8'h1f)};
    run_packet("overlen");
    pkt_q = '{mk(1'b0, 4'd3, 8'h0a), mk(1'b0, 4'd3, 8'h0b), mk(1'b0, 4'd3, 8'h0c),
              mk(1'b1, 4'd3, 8'h0d)};
    run_packet("maxlen");

    // Backpressure with a 2-entry status FIFO.
    send_flit(mk(1'b1, 4'd3, 8'h00));
    send_flit(mk(1'b1, 4'd3, 8'h00));
    exp_recv += 2;
    chk("bp_full_rdy", 32'(r_ready_out), 32'd0);
    chk("bp_recv2", recv_packs, 32'(exp_recv));
    data_i = mk(1'b1, 4'd3, 8'h00);
    wr_ready_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp_held", recv_packs, 32'(exp_recv));
    chk("bp_head_len", 32'(st_len), 32'd1);
    chk("bp_head_err", 32'(st_err), 32'd0);
    st_ready = 1'b1;
    @(posedge clk);
    #1 st_ready = 1'b0;
    @(negedge clk);
    chk("bp_rdy_back", 32'(r_ready_out), 32'd1);
    @(posedge clk);
    #1 wr_ready_in = 1'b0;
    @(negedge clk);
    exp_recv++;
    chk("bp_recv3", recv_packs, 32'(exp_recv));
    chk("bp_full_again", 32'(r_ready_out), 32'd0);
    for (int i = 0; i < 2; i++) begin
      chk("bp_drain_valid", 32'(st_valid), 32'd1);
      chk("bp_drain_len", 32'(st_len), 32'd1);
      chk("bp_drain_err", 32'(st_err), 32'd0);
      st_ready = 1'b1;
      @(posedge clk);
      #1 st_ready = 1'b0;
      @(negedge clk);
    end
    chk("bp_empty", 32'(st_valid), 32'd0);
    chk("bp_errp", err_packs, 32'(exp_err));

    // Randomized packets.
    for (int p = 0; p < 40; p++) begin
      n = $urandom_range(1, MAXP + 2);
      acc = '0;
      pkt_q.delete();
      for (int i = 0; i < n; i++) begin
        a = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'(MY);
        d = 8'($urandom);
        if (i == n - 1) begin
          if ($urandom_range(0, 1) == 1) d = acc;
        end else begin
          acc = acc ^ d;
        end
        pkt_q.push_back(mk(i == n - 1, a, d));
      end
      run_packet("rand");
    end

    // Reset in the middle of a packet.
    send_flit(mk(1'b0, 4'd3, 8'h12));
    send_flit(mk(1'b0, 4'd3, 8'h34));
    a_rst = 1'b0;
    #1;
    exp_recv = 0;
    exp_err = 0;
    chk("mid_rst_rdy", 32'(r_ready_out), 32'd0);
    chk("mid_rst_valid", 32'(st_valid), 32'd0);
    chk("mid_rst_len", 32'(st_len), 32'd0);
    chk("mid_rst_err", 32'(st_err), 32'd0);
    chk("mid_rst_recv", recv_packs, 32'd0);
    chk("mid_rst_errp", err_packs, 32'd0);
    @(negedge clk);
    a_rst = 1'b1;
    @(negedge clk);
    pkt_q = '{mk(1'b0, 4'd3, 8'h12), mk(1'b0, 4'd3, 8'h34), mk(1'b1, 4'd3, 8'h26)};
    run_packet("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ni_rx_checker.md
Name: ni_rx_checker

Overview:
- Receive-side network-interface stage on the switch's local (IP) output port. Sits between the switch's local port and the IP core.
- Consumes flits and reassembles them into packets. Checks each packet's destination address, length and XOR checksum.
- Pushes one status record per packet into a small FIFO for the IP. Keeps running received and errored packet counters that feed the bench's end-of-test sum.

Parameters:
- DATA_SIZE, 8, flit payload width
- ADDR_SIZE, 4, destination-address field width
- ADDR, 0, this node's address
- MAX_PACK_LEN, 8, maximum legal flits per packet (tail included)
- LEN_SIZE, 8, width of reported length; must hold MAX_PACK_LEN+1
- STAT_LOG2, 2, log2 of status-FIFO depth
- FLIT_SIZE, DATA_SIZE+ADDR_SIZE+1, derived; do not override

Ports:
- clk  in  1  clock, rising edge
- a_rst  in  1  reset, asynchronous, active-low
- data_i  in  FLIT_SIZE  flit from switch local port
- wr_ready_in  in  1  switch holds a valid flit
- r_ready_out  out  1  block can accept a flit
- st_valid  out  1  status record available
- st_ready  in  1  IP pops the status record
- st_len  out  LEN_SIZE  flits counted in the packet
- st_err  out  2  bit0 = checksum error, bit1 = address/length error
- recv_packs  out  32  packets completed (ok + errored)
- err_packs  out  32  packets with any st_err bit set

Behaviour:
- Flit layout:
  - bit FLIT_SIZE-1 = tail flag.
  - bits [FLIT_SIZE-2 -: ADDR_SIZE] = destination address.
  - bits [DATA_SIZE-1:0] = data.
- Handshake:
  - A flit is accepted on a rising clk edge when wr_ready_in && r_ready_out.
  - r_ready_out = a_rst && !fifo_full, combinational.
  - Nothing is accepted while the status FIFO is full.
- Checksum: the tail flit's data must equal the XOR of the data of all preceding flits in the packet. For a single-flit packet the tail data must be 0.
- FSM, three states:
  - IDLE (no packet open): a non-tail flit goes to BODY; a tail flit completes a 1-flit packet and stays in IDLE.
  - BODY (accumulating): a tail flit completes the packet and goes to IDLE. When the accepted flit count reaches MAX_PACK_LEN without a tail, set the length error and go to DROP.
  - DROP: discard flits without XOR accumulation until a tail is accepted, then complete the packet and go to IDLE.
- Per-packet state:
  - len counter: counts accepted flits and saturates at MAX_PACK_LEN+1.
  - xor accumulator.
  - sticky addr_err: set if any flit's address differs from ADDR.
  - sticky len_err.
  - All of these clear when the tail is accepted.
- Completion, on the tail-accept edge:
  - Push {len, err} into the FIFO.
  - recv_packs += 1.
  - err_packs += 1 if err != 0.
  - Counters wrap modulo 2^32.
  - Push and pop on the same edge are both honoured, and occupancy is unchanged.
- st_valid = FIFO not empty. st_len and st_err show the FIFO head and are valid while st_valid is high. A pop happens on st_valid && st_ready.
- Reset:
  - While a_rst is low: r_ready_out=0, st_valid=0, st_len=0, st_err=0, recv_packs=0, err_packs=0, FSM=IDLE, FIFO empty.
  - Reset mid-packet discards the partial packet; no status record is produced.
- Latency: the status record is visible on st_valid one cycle after the tail-accept edge.

Decomposition:
- Shared header configs.vh gains the flit field macros: tail-bit index, address offset, and st_err bit positions (CHK_ERR=0, ADDR_ERR=1).
- One sub-module: sync_fifo, parameterised by width (LEN_SIZE+2) and depth log2 (STAT_LOG2). It provides full, empty, push, pop and head data, with asynchronous active-low reset. It is reusable by the switch buffers.

Test Plan:
Defaults: ADDR=3, DATA_SIZE=8, ADDR_SIZE=4.
- Good packet: flits (addr 3, 0x12), (3, 0x34), tail (3, 0x26) -> one record st_len=3, st_err=00; recv_packs=1, err_packs=0.
- Bad checksum: same packet but tail data 0x00 -> st_len=3, st_err=01; err_packs=1. A following 1-flit packet with tail data 0x00 -> st_err=00.
- Wrong address: middle flit carries addr 5 -> st_err=10, st_len=3; recv_packs increments.
- Overlength, MAX_PACK_LEN=4: 6-flit packet with tail on flit 6 -> flits 5–6 dropped; exactly one record st_len=5, st_err=10.
- Backpressure, STAT_LOG2=1: st_ready=0, send three 1-flit packets -> r_ready_out falls after the 2nd tail and the 3rd flit stays held. Pulse st_ready one cycle -> r_ready_out=1 the next cycle and the 3rd flit is accepted.
- Reset mid-packet: assert a_rst after 2 of 3 flits -> outputs and counters read 0 immediately. After release, a fresh good 3-flit packet yields st_len=3, st_err=00, recv_packs=1.
